// File: rtl/spi_adc_pkg.sv
// Shared types and helpers for the SPI ADC responder (MCP3202-style protocol).
// Holds the FSM state encoding, command-length constant and the saturating subtractor.
package spi_adc_pkg;

    localparam int DEFAULT_DATA_W = 12;
    localparam int DEFAULT_CNT_W  = 16;
    localparam int CMD_BITS       = 3;
    localparam int SAT_W          = 32;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CMD,
        ST_NUL,
        ST_DATA,
        ST_LSBF,
        ST_DONE
    } state_t;

    function automatic logic [SAT_W-1:0] sat_sub(input logic [SAT_W-1:0] a,
                                                 input logic [SAT_W-1:0] b);
        return (a > b) ? (a - b) : '0;
    endfunction

endpackage

// File: rtl/spi_adc_responder_sync.sv
// SYNC_STAGES-deep synchronizer for sck/cs_n/mosi with edge detection on the synced sck and cs_n.
module spi_edge_sync
    import spi_adc_pkg::*;
#(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic spi_sck,
    input  logic spi_cs_n,
    input  logic spi_mosi,
    output logic cs_n_lvl,
    output logic mosi_lvl,
    output logic sck_rise,
    output logic sck_fall,
    output logic cs_rise,
    output logic cs_fall
);

    logic [SYNC_STAGES-1:0] sck_pipe_q, sck_pipe_d;
    logic [SYNC_STAGES-1:0] cs_pipe_q, cs_pipe_d;
    logic [SYNC_STAGES-1:0] mosi_pipe_q, mosi_pipe_d;
    logic                   sck_prev_q, sck_prev_d;
    logic                   cs_prev_q, cs_prev_d;

    always_comb begin
        sck_pipe_d  = {sck_pipe_q[SYNC_STAGES-2:0], spi_sck};
        cs_pipe_d   = {cs_pipe_q[SYNC_STAGES-2:0], spi_cs_n};
        mosi_pipe_d = {mosi_pipe_q[SYNC_STAGES-2:0], spi_mosi};
        sck_prev_d  = sck_pipe_q[SYNC_STAGES-1];
        cs_prev_d   = cs_pipe_q[SYNC_STAGES-1];
    end

    // cs_n resets to "selected" so a frame already in progress never produces a
    // fall edge; only a genuine high->low transition can start the next frame.
    always_ff @(posedge clk) begin
        if (rst) begin
            sck_pipe_q  <= '0;
            cs_pipe_q   <= '0;
            mosi_pipe_q <= '0;
            sck_prev_q  <= 1'b0;
            cs_prev_q   <= 1'b0;
        end else begin
            sck_pipe_q  <= sck_pipe_d;
            cs_pipe_q   <= cs_pipe_d;
            mosi_pipe_q <= mosi_pipe_d;
            sck_prev_q  <= sck_prev_d;
            cs_prev_q   <= cs_prev_d;
        end
    end

    always_comb begin
        cs_n_lvl = cs_pipe_q[SYNC_STAGES-1];
        mosi_lvl = mosi_pipe_q[SYNC_STAGES-1];
        sck_rise = sck_pipe_q[SYNC_STAGES-1] & ~sck_prev_q;
        sck_fall = ~sck_pipe_q[SYNC_STAGES-1] & sck_prev_q;
        cs_rise  = cs_pipe_q[SYNC_STAGES-1] & ~cs_prev_q;
        cs_fall  = ~cs_pipe_q[SYNC_STAGES-1] & cs_prev_q;
    end

endmodule

// File: rtl/spi_adc_responder.sv
// SPI responder emulating a dual-channel MCP3202 ADC: decodes START/SGL/ODD/MSBF, shifts a snapshot out on miso.
// Optional feature macro: SPI_ADC_RESP_LSBF_EN (LSB-first tail after B0 when MSBF=0).
module spi_adc_responder
    import spi_adc_pkg::*;
#(
    parameter int DATA_W      = DEFAULT_DATA_W,
    parameter int SYNC_STAGES = 2,
    parameter int CNT_W       = DEFAULT_CNT_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              spi_sck,
    input  logic              spi_cs_n,
    input  logic              spi_mosi,
    output logic              spi_miso,
    input  logic [DATA_W-1:0] ch0_value,
    input  logic [DATA_W-1:0] ch1_value,
    output logic              frame_done,
    output logic              frame_err,
    output logic              last_ch,
    output logic              last_sgl,
    output logic [CNT_W-1:0]  frame_cnt
);

    localparam int CBW = $clog2(DATA_W) + 1;

    logic cs_n_lvl, mosi_lvl, sck_rise, sck_fall, cs_rise, cs_fall;
    logic sck_rise_v, sck_fall_v;

    spi_edge_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
        .clk      (clk),
        .rst      (rst),
        .spi_sck  (spi_sck),
        .spi_cs_n (spi_cs_n),
        .spi_mosi (spi_mosi),
        .cs_n_lvl (cs_n_lvl),
        .mosi_lvl (mosi_lvl),
        .sck_rise (sck_rise),
        .sck_fall (sck_fall),
        .cs_rise  (cs_rise),
        .cs_fall  (cs_fall)
    );

    state_t             state_q, state_d;
    logic [CBW-1:0]     bit_cnt_q, bit_cnt_d;
    logic [DATA_W-1:0]  shreg_q, shreg_d;
    logic [1:0]         cmd_cnt_q, cmd_cnt_d;
    logic               sgl_q, sgl_d;
    logic               odd_q, odd_d;
    logic               miso_q, miso_d;
    logic               done_q, done_d;
    logic               err_q, err_d;
    logic               last_ch_q, last_ch_d;
    logic               last_sgl_q, last_sgl_d;
    logic [CNT_W-1:0]   frame_cnt_q, frame_cnt_d;
`ifdef SPI_ADC_RESP_LSBF_EN
    logic               msbf_q, msbf_d;
`endif

    logic [SAT_W-1:0]   diff_w;
    logic [DATA_W-1:0]  sel_value;

    always_comb begin
        sck_rise_v = sck_rise & ~cs_n_lvl;
        sck_fall_v = sck_fall & ~cs_n_lvl;
        diff_w = odd_q ? sat_sub(SAT_W'(ch1_value), SAT_W'(ch0_value))
                       : sat_sub(SAT_W'(ch0_value), SAT_W'(ch1_value));
        if (sgl_q) sel_value = odd_q ? ch1_value : ch0_value;
        else       sel_value = DATA_W'(diff_w);
    end

    always_comb begin
        state_d     = state_q;
        bit_cnt_d   = bit_cnt_q;
        shreg_d     = shreg_q;
        cmd_cnt_d   = cmd_cnt_q;
        sgl_d       = sgl_q;
        odd_d       = odd_q;
        miso_d      = miso_q;
        done_d      = 1'b0;
        err_d       = 1'b0;
        last_ch_d   = last_ch_q;
        last_sgl_d  = last_sgl_q;
        frame_cnt_d = frame_cnt_q;
`ifdef SPI_ADC_RESP_LSBF_EN
        msbf_d      = msbf_q;
`endif
        // cs_n release outranks any sck edge arriving in the same cycle.
        if (state_q != ST_IDLE && cs_rise) begin
            state_d = ST_IDLE;
            miso_d  = 1'b0;
            case (state_q)
                ST_DONE: begin
                    done_d      = 1'b1;
                    frame_cnt_d = frame_cnt_q + 1'b1;
                end
                ST_NUL, ST_DATA, ST_LSBF: err_d = 1'b1;
                default: ;
            endcase
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (cs_fall) begin
                        state_d   = ST_CMD;
                        cmd_cnt_d = '0;
                        miso_d    = 1'b0;
                    end
                end
                ST_CMD: begin
                    if (sck_rise_v) begin
                        if (cmd_cnt_q == '0) begin
                            if (mosi_lvl) cmd_cnt_d = 2'd1;
                        end else if (cmd_cnt_q == 2'(CMD_BITS)) begin
                            shreg_d    = sel_value;
                            last_ch_d  = odd_q;
                            last_sgl_d = sgl_q;
                            state_d    = ST_NUL;
`ifdef SPI_ADC_RESP_LSBF_EN
                            msbf_d     = mosi_lvl;
`endif
                        end else begin
                            cmd_cnt_d = cmd_cnt_q + 1'b1;
                            if (cmd_cnt_q == 2'd1) sgl_d = mosi_lvl;
                            else                   odd_d = mosi_lvl;
                        end
                    end
                end
                ST_NUL: begin
                    if (sck_fall_v) begin
                        miso_d    = 1'b0;
                        bit_cnt_d = CBW'(DATA_W - 1);
                        state_d   = ST_DATA;
                    end
                end
                ST_DATA: begin
                    if (sck_fall_v) begin
                        // Rotate so the snapshot is intact again after B0 for the LSB-first tail.
                        miso_d  = shreg_q[DATA_W-1];
                        shreg_d = {shreg_q[DATA_W-2:0], shreg_q[DATA_W-1]};
                        if (bit_cnt_q == '0) begin
`ifdef SPI_ADC_RESP_LSBF_EN
                            if (!msbf_q) begin
                                state_d   = ST_LSBF;
                                bit_cnt_d = CBW'(DATA_W - 2);
                            end else begin
                                state_d = ST_DONE;
                            end
`else
                            state_d = ST_DONE;
`endif
                        end else begin
                            bit_cnt_d = bit_cnt_q - 1'b1;
                        end
                    end
                end
`ifdef SPI_ADC_RESP_LSBF_EN
                ST_LSBF: begin
                    if (sck_fall_v) begin
                        miso_d  = shreg_q[1];
                        shreg_d = shreg_q >> 1;
                        if (bit_cnt_q == '0) state_d = ST_DONE;
                        else                 bit_cnt_d = bit_cnt_q - 1'b1;
                    end
                end
`endif
                ST_DONE: begin
                    if (sck_fall_v) miso_d = 1'b0;
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            bit_cnt_q   <= '0;
            shreg_q     <= '0;
            cmd_cnt_q   <= '0;
            sgl_q       <= 1'b0;
            odd_q       <= 1'b0;
            miso_q      <= 1'b0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
            last_ch_q   <= 1'b0;
            last_sgl_q  <= 1'b0;
            frame_cnt_q <= '0;
`ifdef SPI_ADC_RESP_LSBF_EN
            msbf_q      <= 1'b1;
`endif
        end else begin
            state_q     <= state_d;
            bit_cnt_q   <= bit_cnt_d;
            shreg_q     <= shreg_d;
            cmd_cnt_q   <= cmd_cnt_d;
            sgl_q       <= sgl_d;
            odd_q       <= odd_d;
            miso_q      <= miso_d;
            done_q      <= done_d;
            err_q       <= err_d;
            last_ch_q   <= last_ch_d;
            last_sgl_q  <= last_sgl_d;
            frame_cnt_q <= frame_cnt_d;
`ifdef SPI_ADC_RESP_LSBF_EN
            msbf_q      <= msbf_d;
`endif
        end
    end

    always_comb begin
        spi_miso   = miso_q;
        frame_done = done_q;
        frame_err  = err_q;
        last_ch    = last_ch_q;
        last_sgl   = last_sgl_q;
        frame_cnt  = frame_cnt_q;
    end

endmodule

// File: tb/tb_spi_adc_responder.sv
// Randomized self-checking bench for spi_adc_responder against a frame-level reference model.
module tb_spi_adc_responder;

    localparam int DW   = 12;
    localparam int SS   = 2;
    localparam int CW   = 4;
    localparam int HALF = 6;
`ifdef SPI_ADC_RESP_LSBF_EN
    localparam bit LSBF_BUILT = 1'b1;
`else
    localparam bit LSBF_BUILT = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst, spi_sck, spi_cs_n, spi_mosi;
    logic          spi_miso, frame_done, frame_err, last_ch, last_sgl;
    logic [DW-1:0] ch0_value, ch1_value;
    logic [CW-1:0] frame_cnt;

    int n_tests = 0;
    int n_fail  = 0;
    int done_cnt = 0, err_cnt = 0;
    int done_exp = 0, err_exp = 0, cnt_exp = 0;

    spi_adc_responder #(.DATA_W(DW), .SYNC_STAGES(SS), .CNT_W(CW)) dut (
        .clk        (clk),
        .rst        (rst),
        .spi_sck    (spi_sck),
        .spi_cs_n   (spi_cs_n),
        .spi_mosi   (spi_mosi),
        .spi_miso   (spi_miso),
        .ch0_value  (ch0_value),
        .ch1_value  (ch1_value),
        .frame_done (frame_done),
        .frame_err  (frame_err),
        .last_ch    (last_ch),
        .last_sgl   (last_sgl),
        .frame_cnt  (frame_cnt)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (frame_done) done_cnt++;
        if (frame_err)  err_cnt++;
    end

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation time limit reached, tests=%0d", n_tests);
        $fatal(1, "watchdog");
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reference: MCP3202 conversion result from the command bits and current channel values.
    function automatic logic [DW-1:0] ref_value(input logic sgl, input logic odd,
                                                input logic [DW-1:0] a, input logic [DW-1:0] b);
        int d;
        if (sgl) return odd ? b : a;
        d = odd ? (int'(b) - int'(a)) : (int'(a) - int'(b));
        if (d < 0) d = 0;
        return d[DW-1:0];
    endfunction

    task automatic wait_clks(input int n);
        repeat (n) @(negedge clk);
    endtask

    // One SCK period: miso is sampled just before the rise, as a mode-0 initiator does.
    task automatic bit_cycle(input logic b, output logic m);
        wait_clks(HALF / 2);
        spi_mosi = b;
        wait_clks(HALF - HALF / 2);
        m = spi_miso;
        spi_sck = 1'b1;
        wait_clks(HALF);
        spi_sck = 1'b0;
    endtask

    task automatic close_frame_checks(input string tag);
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (done_cnt >= done_exp && err_cnt >= err_exp) break;
        end
        wait_clks(3);
        check_eq({tag, "_done"}, done_cnt, done_exp);
        check_eq({tag, "_err"}, err_cnt, err_exp);
        check_eq({tag, "_fcnt"}, frame_cnt, cnt_exp);
        check_eq({tag, "_miso_idle"}, spi_miso, 1'b0);
        wait_clks(HALF);
    endtask

    // kill: 0 = complete frame, 1 = release cs_n before data bit kill_at, 2 = assert rst there.
    task automatic run_frame(input string tag, input logic sgl, input logic odd, input logic msbf,
                             input int lead, input int kill, input int kill_at,
                             input int chg_at, input logic [DW-1:0] new0, input logic [DW-1:0] new1);
        logic [DW-1:0] exp_v, got_v, got_l;
        logic          m, acc;
        exp_v = ref_value(sgl, odd, ch0_value, ch1_value);
        spi_cs_n = 1'b0;
        wait_clks(HALF);
        for (int i = 0; i < lead; i++) bit_cycle(1'b0, m);
        bit_cycle(1'b1, m);
        bit_cycle(sgl, m);
        bit_cycle(odd, m);
        bit_cycle(msbf, m);
        bit_cycle($urandom_range(0, 1), m);
        check_eq({tag, "_null"}, m, 1'b0);
        check_eq({tag, "_last_ch"}, last_ch, odd);
        check_eq({tag, "_last_sgl"}, last_sgl, sgl);
        got_v = '0;
        for (int i = 0; i < DW; i++) begin
            if (i == chg_at) begin
                ch0_value = new0;
                ch1_value = new1;
            end
            if (kill == 1 && i == kill_at) begin
                spi_cs_n = 1'b1;
                err_exp++;
                wait_clks(SS + 2);
                check_eq({tag, "_abort_miso"}, spi_miso, 1'b0);
                close_frame_checks({tag, "_abort"});
                return;
            end
            if (kill == 2 && i == kill_at) begin
                rst = 1'b1;
                wait_clks(2);
                rst = 1'b0;
                cnt_exp = 0;
                @(negedge clk);
                check_eq({tag, "_rst_miso"}, spi_miso, 1'b0);
                check_eq({tag, "_rst_done"}, frame_done, 1'b0);
                check_eq({tag, "_rst_err"}, frame_err, 1'b0);
                check_eq({tag, "_rst_last_ch"}, last_ch, 1'b0);
                check_eq({tag, "_rst_last_sgl"}, last_sgl, 1'b0);
                check_eq({tag, "_rst_fcnt"}, frame_cnt, '0);
                acc = 1'b0;
                for (int k = 0; k < 8; k++) begin
                    bit_cycle(1'b1, m);
                    acc |= m;
                end
                check_eq({tag, "_rst_ignored_miso"}, acc, 1'b0);
                check_eq({tag, "_rst_ignored_ch"}, last_ch, 1'b0);
                spi_cs_n = 1'b1;
                close_frame_checks({tag, "_rst"});
                return;
            end
            bit_cycle($urandom_range(0, 1), m);
            got_v = {got_v[DW-2:0], m};
        end
        check_eq({tag, "_data"}, got_v, exp_v);
        if (LSBF_BUILT && !msbf) begin
            got_l = '0;
            for (int j = 1; j < DW; j++) begin
                bit_cycle(1'b0, m);
                got_l[j] = m;
            end
            check_eq({tag, "_lsbf"}, got_l, exp_v & ~DW'(1));
        end
        acc = 1'b0;
        for (int k = 0; k < 2; k++) begin
            bit_cycle(1'b1, m);
            acc |= m;
        end
        check_eq({tag, "_trail"}, acc, 1'b0);
        spi_cs_n = 1'b1;
        done_exp++;
        cnt_exp = (cnt_exp + 1) % (1 << CW);
        close_frame_checks(tag);
    endtask

    initial begin
        logic m;
        logic [DW-1:0] n0, n1;
        rst = 1'b1; spi_cs_n = 1'b1; spi_sck = 1'b0; spi_mosi = 1'b0;
        ch0_value = '0; ch1_value = '0;
        wait_clks(5);
        rst = 1'b0;
        wait_clks(5);
        check_eq("reset_miso", spi_miso, 1'b0);
        check_eq("reset_done", frame_done, 1'b0);
        check_eq("reset_err", frame_err, 1'b0);
        check_eq("reset_last_ch", last_ch, 1'b0);
        check_eq("reset_last_sgl", last_sgl, 1'b0);
        check_eq("reset_fcnt", frame_cnt, '0);

        ch0_value = 12'hA5C; ch1_value = 12'h3C3;
        run_frame("sgl_ch0", 1'b1, 1'b0, 1'b1, 2, 0, 0, -1, '0, '0);
        ch0_value = 12'h100; ch1_value = 12'h300;
        run_frame("diff_sat", 1'b0, 1'b0, 1'b1, 0, 0, 0, -1, '0, '0);
        run_frame("diff_pos", 1'b0, 1'b1, 1'b1, 1, 0, 0, -1, '0, '0);
        ch0_value = 12'h801;
        run_frame("lsbf", 1'b1, 1'b0, 1'b0, 0, 0, 0, -1, '0, '0);
        ch1_value = 12'h0FF;
        run_frame("coherent", 1'b1, 1'b1, 1'b1, 0, 0, 0, 3, ch0_value, 12'hF00);
        run_frame("after_chg", 1'b1, 1'b1, 1'b1, 0, 0, 0, -1, '0, '0);
        ch0_value = 12'hFFF;
        run_frame("cs_abort", 1'b1, 1'b0, 1'b1, 0, 1, 5, -1, '0, '0);

        spi_cs_n = 1'b0;
        wait_clks(HALF);
        bit_cycle(1'b1, m);
        bit_cycle(1'b1, m);
        spi_cs_n = 1'b1;
        close_frame_checks("cmd_abort");

        ch1_value = 12'hFFF;
        run_frame("rst_mid", 1'b1, 1'b1, 1'b1, 0, 2, 4, -1, '0, '0);
        ch0_value = 12'h123; ch1_value = 12'h456;
        run_frame("post_rst", 1'b0, 1'b1, 1'b0, 1, 0, 0, -1, '0, '0);

        for (int r = 0; r < 22; r++) begin
            ch0_value = DW'($urandom);
            ch1_value = DW'($urandom);
            n0 = DW'($urandom);
            n1 = DW'($urandom);
            run_frame("rand", 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                      1'($urandom_range(0, 1)), $urandom_range(0, 3), 0, 0,
                      $urandom_range(0, DW + 3), n0, n1);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
